fifo_read_arbiter: RTL and testbench
====================================

FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of source FIFOs (legal 2..16).
REQ-002 SHALL have parameter WIDTH, default 32, data width of every FIFO and of the output.
REQ-003 SHALL have parameter BURST, default 8, maximum transfers per grant (legal 1..256).
REQ-004 SHALL define localparam PORTBITS = $clog2(NUM_PORTS) and CNTBITS = $clog2(BURST+1).
REQ-005 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port_enable  input  NUM_PORTS  per-port arbitration enable.
REQ-008 SHALL have fifo_empty  input  NUM_PORTS  empty flag of each source FIFO.
REQ-009 SHALL have fifo_dataout  input  NUM_PORTS*WIDTH  first-word-fallthrough head word of each FIFO; port i in bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have fifo_read  output  NUM_PORTS  one-hot read strobe to the source FIFOs.
REQ-011 SHALL have out_data  output  WIDTH  granted head word.
REQ-012 SHALL have out_valid  output  1  out_data is valid this cycle.
REQ-013 SHALL have out_ready  input  1  downstream accepts out_data.
REQ-014 SHALL have out_port  output  PORTBITS  index of the granted port.
REQ-015 SHALL have out_last  output  1  current transfer ends the grant because the BURST limit is reached.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and BURST.
REQ-017 SHALL define req[i] = port_enable[i] && !fifo_empty[i].
REQ-018 In IDLE with any req set, SHALL register the first requesting port after last_grant, searching round-robin (last_grant+1, +2, ... with wrap modulo NUM_PORTS), as grant, clear count, and enter BURST next cycle.
REQ-019 In IDLE with no req, SHALL stay in IDLE; grant selection SHALL take exactly one cycle, with no transfer in IDLE.
REQ-020 In BURST, out_valid SHALL equal req[grant] (combinational); out_data SHALL be the grant slice of fifo_dataout; out_port SHALL equal grant.
REQ-021 A transfer SHALL occur when out_valid && out_ready; in that cycle fifo_read[grant] SHALL be 1; at all other times fifo_read SHALL be all zero.
REQ-022 On each transfer, count SHALL increment by 1.
REQ-023 out_last SHALL be out_valid && (count == BURST-1).
REQ-024 A transfer with count == BURST-1 SHALL end the grant: next state IDLE, last_grant <= grant.
REQ-025 In BURST with req[grant] == 0, caused by an empty FIFO or a deasserted port_enable, SHALL end the grant with no transfer: next state IDLE, last_grant <= grant.
REQ-026 In BURST with out_valid && !out_ready, SHALL hold grant, count, out_data and out_valid stable.
REQ-027 Only the granted port SHALL matter during BURST; req changes on other ports SHALL not affect the current grant.
REQ-028 With a single requesting port, it SHALL be re-granted after exactly one IDLE cycle.
REQ-029 With BURST == 1, every transfer SHALL assert out_last and return to IDLE.

Reset
REQ-030 While reset is high, SHALL asynchronously force state=IDLE, grant=0, count=0 and last_grant=NUM_PORTS-1, so that port 0 is checked first.
REQ-031 While reset is high, out_valid, out_last and fifo_read SHALL be 0.
REQ-032 Reset asserted mid-burst SHALL abort the grant with no further read strobe; after release, arbitration SHALL restart from port 0.

Structure
REQ-033 SHALL place the FSM state enum (ARB_IDLE, ARB_BURST) in shared package libfifo_pkg, alongside the fifo fillStatus typedef.
REQ-034 SHALL implement the round-robin search as one sub-module rr_select, parameterised by NUM_PORTS, with inputs req and last and outputs found and index.
REQ-035 SHALL infer no memory; all storage SHALL be flops for state, grant, last_grant and count.

Verification
REQ-036 Bench SHALL cover: ports 0..3 all non-empty with 20 words each, out_ready=1, BURST=8 -> port order 0,1,2,3,0,...; each grant 8 words with out_last on the 8th; one idle cycle between grants.
REQ-037 Bench SHALL cover: port 2 only, holding 3 words, BURST=8 -> 3 transfers with out_port=2 and no out_last, then IDLE once fifo_empty[2] rises.
REQ-038 Bench SHALL cover: out_ready toggling 1,0,0,1 during a grant -> out_data held during the stall, fifo_read[grant] high only in ready cycles, word order preserved.
REQ-039 Bench SHALL cover: port_enable[1] dropped after 2 transfers of port 1 -> grant ends with no transfer that cycle; the next grant goes to port 2, not port 1.
REQ-040 Bench SHALL cover: reset pulsed during the 4th transfer of port 0 -> fifo_read and out_valid 0 immediately; after release, the first grant is port 0, not port 1.
REQ-041 Bench SHALL cover: NUM_PORTS=3, BURST=1, all ports requesting -> grants 0,1,2,0 with wrap, out_last on every transfer.

Source files
------------

// File: rtl/libfifo_pkg.sv
// Shared types for the FIFO library: arbiter FSM states and FIFO fill status.
package libfifo_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    FILL_EMPTY       = 2'd0,
    FILL_PARTIAL     = 2'd1,
    FILL_ALMOST_FULL = 2'd2,
    FILL_FULL        = 2'd3
  } fill_status_t;

  // Almost-full means one free slot or fewer remains.
  function automatic fill_status_t fill_status(input int unsigned level,
                                               input int unsigned depth);
    fill_status_t status;
    if (level == 0)
      status = FILL_EMPTY;
    else if (level >= depth)
      status = FILL_FULL;
    else if (level + 1 >= depth)
      status = FILL_ALMOST_FULL;
    else
      status = FILL_PARTIAL;
    return status;
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_select.sv
// Round-robin search: first set req bit strictly after 'last', wrapping modulo NUM_PORTS.
module rr_select #(
  parameter int NUM_PORTS = 4,
  localparam int PORTBITS = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORTBITS-1:0]  last,
  output logic                 found,
  output logic [PORTBITS-1:0]  index
);

  int unsigned          cand;
  logic [PORTBITS-1:0]  cand_idx;

  // Scan farthest-first so the nearest candidate after 'last' overwrites the rest.
  always_comb begin
    found    = 1'b0;
    index    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand     = (int'(last) + i) % NUM_PORTS;
      cand_idx = cand[PORTBITS-1:0];
      if (req[cand_idx]) begin
        found = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin read arbiter draining up to BURST words per grant from FWFT source FIFOs.
//   state     | meaning
//   ARB_IDLE  | no grant held; one cycle to pick the next requester after last_grant
//   ARB_BURST | grant held; transfers on out_valid && out_ready until BURST or req drops
module fifo_read_arbiter
  import libfifo_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 32,
  parameter int BURST     = 8,
  localparam int PORTBITS = $clog2(NUM_PORTS),
  localparam int CNTBITS  = $clog2(BURST + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       port_enable,
  input  logic [NUM_PORTS-1:0]       fifo_empty,
  input  logic [NUM_PORTS*WIDTH-1:0] fifo_dataout,
  output logic [NUM_PORTS-1:0]       fifo_read,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PORTBITS-1:0]        out_port,
  output logic                       out_last
);

  localparam logic [CNTBITS-1:0]  LAST_COUNT = CNTBITS'(BURST - 1);
  localparam logic [PORTBITS-1:0] LAST_PORT  = PORTBITS'(NUM_PORTS - 1);

  arb_state_t            state;
  logic [PORTBITS-1:0]   grant;
  logic [PORTBITS-1:0]   last_grant;
  logic [CNTBITS-1:0]    count;

  logic [NUM_PORTS-1:0]  req;
  logic                  req_grant;
  logic                  sel_found;
  logic [PORTBITS-1:0]   sel_index;
  logic                  transfer;
  logic                  at_limit;

  assign req       = port_enable & ~fifo_empty;
  assign req_grant = req[grant];
  assign at_limit  = (count == LAST_COUNT);
  assign out_valid = (state == ARB_BURST) && req_grant;
  assign transfer  = out_valid && out_ready;
  assign out_last  = out_valid && at_limit;
  assign out_port  = grant;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == PORTBITS'(i))
        out_data = fifo_dataout[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    fifo_read = '0;
    if (transfer)
      fifo_read[grant] = 1'b1;
  end

  rr_select #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_select (
    .req   (req),
    .last  (last_grant),
    .found (sel_found),
    .index (sel_index)
  );

  // last_grant resets to the top port so the first search after reset lands on port 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      count      <= '0;
      last_grant <= LAST_PORT;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (sel_found) begin
            grant <= sel_index;
            count <= '0;
            state <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (!req_grant) begin
            last_grant <= grant;
            state      <= ARB_IDLE;
          end else if (transfer) begin
            count <= count + CNTBITS'(1);
            if (at_limit) begin
              last_grant <= grant;
              state      <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Self-checking bench: queue-backed FIFOs, grant-level reference model, directed tables and random traffic.
module tb_fifo_read_arbiter;

  localparam int A_N     = 4;
  localparam int A_W     = 32;
  localparam int A_BURST = 8;
  localparam int B_N     = 3;
  localparam int B_W     = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [A_N-1:0]     a_en, a_empty, a_read;
  logic [A_N*A_W-1:0] a_data;
  logic [A_W-1:0]     a_out_data;
  logic               a_valid, a_ready, a_last;
  logic [1:0]         a_port;

  logic [B_N-1:0]     b_en, b_empty, b_read;
  logic [B_N*B_W-1:0] b_data;
  logic [B_W-1:0]     b_out_data;
  logic               b_valid, b_ready, b_last;
  logic [1:0]         b_port;

  fifo_read_arbiter #(.NUM_PORTS(A_N), .WIDTH(A_W), .BURST(A_BURST)) u_a (
    .clk(clk), .reset(reset), .port_enable(a_en), .fifo_empty(a_empty),
    .fifo_dataout(a_data), .fifo_read(a_read), .out_data(a_out_data),
    .out_valid(a_valid), .out_ready(a_ready), .out_port(a_port), .out_last(a_last));

  fifo_read_arbiter #(.NUM_PORTS(B_N), .WIDTH(B_W), .BURST(1)) u_b (
    .clk(clk), .reset(reset), .port_enable(b_en), .fifo_empty(b_empty),
    .fifo_dataout(b_data), .fifo_read(b_read), .out_data(b_out_data),
    .out_valid(b_valid), .out_ready(b_ready), .out_port(b_port), .out_last(b_last));

  int n_checks = 0;
  int n_errors = 0;

  logic [A_W-1:0] q[A_N][$];
  int log_port[$];
  bit log_last[$];

  // Reference model: which port owns the output, how many words it has sent, who owned it last.
  int m_owner, m_used, m_prev;
  int n_owner, n_used, n_prev;
  logic           e_valid, e_last;
  logic [A_N-1:0] e_read;
  logic [A_W-1:0] e_data;
  int             e_port;

  logic           s_valid, s_last;
  logic [A_N-1:0] s_read;
  logic [A_W-1:0] s_data;

  typedef struct {
    logic           ready;
    logic           valid;
    logic [A_N-1:0] rd;
    logic [A_W-1:0] data;
    logic           last;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_used  = 0;
    m_prev  = A_N - 1;
  endtask

  function automatic bit port_req(input int p);
    return a_en[p] && (q[p].size() > 0);
  endfunction

  function automatic bit busy();
    bit b;
    b = (m_owner >= 0);
    for (int i = 0; i < A_N; i++)
      if (port_req(i)) b = 1'b1;
    return b;
  endfunction

  task automatic model_eval();
    int p;
    n_owner = m_owner; n_used = m_used; n_prev = m_prev;
    e_valid = 1'b0; e_last = 1'b0; e_read = '0; e_data = '0; e_port = 0;
    if (m_owner < 0) begin
      for (int k = 1; k <= A_N; k++) begin
        p = (m_prev + k) % A_N;
        if (n_owner < 0 && port_req(p)) begin
          n_owner = p;
          n_used  = 0;
        end
      end
    end else if (!port_req(m_owner)) begin
      n_prev  = m_owner;
      n_owner = -1;
    end else begin
      e_valid = 1'b1;
      e_port  = m_owner;
      e_data  = q[m_owner][0];
      e_last  = (m_used == A_BURST - 1);
      if (a_ready) begin
        e_read[m_owner] = 1'b1;
        n_used = m_used + 1;
        if (n_used == A_BURST) begin
          n_prev  = m_owner;
          n_owner = -1;
        end
      end
    end
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < A_N; i++) begin
      a_empty[i] = (q[i].size() == 0);
      a_data[i*A_W +: A_W] = (q[i].size() > 0) ? q[i][0] : '0;
    end
  endtask

  task automatic cycle();
    logic [A_N-1:0] rd;
    drive_fifo();
    model_eval();
    @(negedge clk);
    s_valid = a_valid; s_last = a_last; s_read = a_read; s_data = a_out_data;
    chk("fifo_read", a_read, e_read);
    chk("out_valid", a_valid, e_valid);
    chk("out_last", a_last, e_last);
    if (e_valid) begin
      chk("out_data", a_out_data, e_data);
      chk("out_port", a_port, e_port);
    end
    rd = a_read;
    if (rd != '0) begin
      log_port.push_back(int'(a_port));
      log_last.push_back(a_last);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < A_N; i++)
      if (rd[i] && q[i].size() > 0) void'(q[i].pop_front());
    m_owner = n_owner; m_used = n_used; m_prev = n_prev;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, busy(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p1;
    tbl[0] = '{1'b1, 1'b0, 4'b0000, 32'h0,         1'b0};
    tbl[1] = '{1'b1, 1'b1, 4'b1000, 32'hC0DE_0000, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 4'b0000, 32'hC0DE_0001, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 4'b0000, 32'hC0DE_0001, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 4'b1000, 32'hC0DE_0001, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 4'b1000, 32'hC0DE_0002, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 4'b1000, 32'hC0DE_0003, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 4'b0000, 32'h0,         1'b0};
    tbl[8] = '{1'b1, 1'b0, 4'b0000, 32'h0,         1'b0};

    // Reset with requests pending on both instances: outputs must stay quiet.
    reset = 1'b1;
    a_en = '1; a_ready = 1'b1;
    for (int i = 0; i < A_N; i++) q[i].push_back(32'hDEAD_0000 + i);
    drive_fifo();
    b_en = '1; b_empty = '0; b_ready = 1'b1;
    for (int i = 0; i < B_N; i++) b_data[i*B_W +: B_W] = 16'h00B0 + 16'(i);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_read", a_read, 0);
    chk("rst_a_last", a_last, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_read", b_read, 0);
    for (int i = 0; i < A_N; i++) q[i].delete();
    a_en = '0;
    drive_fifo();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Three ports, BURST=1: grants alternate with idle cycles, 0,1,2,0, each transfer is last.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c % 2 == 0) begin
        chk("b_idle_valid", b_valid, 0);
        chk("b_idle_read", b_read, 0);
      end else begin
        p1 = ((c - 1) / 2) % B_N;
        chk("b_valid", b_valid, 1);
        chk("b_port", b_port, p1);
        chk("b_last", b_last, 1);
        chk("b_read", b_read, 64'(1) << p1);
        chk("b_data", b_out_data, 16'h00B0 + 16'(p1));
      end
      @(posedge clk);
      #1;
    end
    b_en = '0;
    b_empty = '1;

    // Four full ports, ready held high: 8-word bursts in strict rotation.
    log_port.delete(); log_last.delete();
    for (int i = 0; i < A_N; i++)
      for (int w = 0; w < 20; w++) q[i].push_back((i << 16) | w);
    a_en = '1; a_ready = 1'b1;
    drain("rr", 300);
    chk("rr_count", log_port.size(), 80);
    for (int k = 0; k < log_port.size(); k++) begin
      chk("rr_port", log_port[k], (k < 64) ? (k / 8) % 4 : (k - 64) / 4);
      chk("rr_last", log_last[k], (k < 64) && (k % 8 == 7));
    end

    // Single port with fewer words than a burst: grant ends on empty, never on last.
    log_port.delete(); log_last.delete();
    for (int w = 0; w < 3; w++) q[2].push_back(32'h2200 + w);
    a_en = 4'b0100;
    drain("short", 40);
    chk("short_count", log_port.size(), 3);
    for (int k = 0; k < log_port.size(); k++) begin
      chk("short_port", log_port[k], 2);
      chk("short_last", log_last[k], 0);
    end

    // Enable of the granted port drops after two transfers; next grant moves on to port 2.
    log_port.delete(); log_last.delete();
    for (int w = 0; w < 5; w++) q[1].push_back(32'h1100 + w);
    for (int w = 0; w < 3; w++) q[2].push_back(32'h2300 + w);
    a_en = 4'b0110;
    n = 0;
    p1 = 0;
    while (p1 < 2 && n < 40) begin
      cycle();
      n++;
      p1 = 0;
      foreach (log_port[k]) if (log_port[k] == 1) p1++;
    end
    chk("drop_reach", p1, 2);
    a_en[1] = 1'b0;
    cycle();
    chk("drop_no_read", s_read, 0);
    chk("drop_no_valid", s_valid, 0);
    a_en[1] = 1'b1;
    drain("drop", 60);
    chk("drop_count", log_port.size(), 8);
    for (int k = 0; k < log_port.size(); k++)
      chk("drop_order", log_port[k], (k < 2 || k > 4) ? 1 : 2);

    // Stall pattern 1,0,0,1 on out_ready, compared against a fixed per-cycle table.
    for (int w = 0; w < 4; w++) q[3].push_back(32'hC0DE_0000 + w);
    a_en = 4'b1000;
    for (int r = 0; r < 9; r++) begin
      a_ready = tbl[r].ready;
      cycle();
      chk($sformatf("tbl%0d_valid", r), s_valid, tbl[r].valid);
      chk($sformatf("tbl%0d_read", r), s_read, tbl[r].rd);
      chk($sformatf("tbl%0d_last", r), s_last, tbl[r].last);
      if (tbl[r].valid) chk($sformatf("tbl%0d_data", r), s_data, tbl[r].data);
    end
    a_ready = 1'b1;
    drain("tbl", 20);

    // Reset pulse during the 4th transfer of port 0; arbitration restarts at port 0.
    for (int w = 0; w < 10; w++) begin
      q[0].push_back(32'hA000 + w);
      q[1].push_back(32'hB000 + w);
    end
    a_en = 4'b0011;
    n = 0;
    while (!(m_owner == 0 && m_used == 3) && n < 40) begin
      cycle();
      n++;
    end
    chk("rst_reach", (m_owner == 0 && m_used == 3), 1);
    drive_fifo();
    #1;
    chk("pre_rst_valid", a_valid, 1);
    chk("pre_rst_read", a_read, 4'b0001);
    reset = 1'b1;
    #1;
    chk("mid_rst_read", a_read, 0);
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_last", a_last, 0);
    @(posedge clk);
    #1;
    chk("held_rst_read", a_read, 0);
    reset = 1'b0;
    model_reset();
    log_port.delete(); log_last.delete();
    drain("rst", 100);
    chk("rst_count", log_port.size(), 17);
    if (log_port.size() > 0) chk("rst_first_port", log_port[0], 0);

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < A_N; i++)
        if ($urandom_range(0, 3) == 0 && q[i].size() < 8) q[i].push_back($urandom());
      a_en = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'hF;
      a_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    a_en = '1;
    a_ready = 1'b1;
    drain("rand", 400);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
